e203_exu_indep_mul_wbck_buf: RTL

- Producer-side buffer for the indep_mul write-back channel into the EXU write-back arbiter.
- Holds single-cycle multiplier results in a small FIFO while the arbiter back-pressures, which happens whenever a long-pipe write-back is valid.
- Presents the head entry on the indep_mul_wbck valid/ready interface.
- Exposes a register-dependency check so the dispatch stage can stall readers of a still-buffered destination register.

---
 rtl/e203_exu_indep_mul_wbck_buf_pkg.sv | 10 +
 rtl/e203_exu_wbck_fifo_entry.sv | 49 ++++
 rtl/e203_exu_indep_mul_wbck_buf.sv | 110 +++++++++++
 3 files changed

// File: rtl/e203_exu_indep_mul_wbck_buf_pkg.sv
// Shared widths and depth for the indep_mul write-back buffer slice.
package e203_exu_indep_mul_wbck_buf_pkg;

  localparam int E203_XLEN                      = 32;
  localparam int E203_RFIDX_WIDTH               = 5;
  localparam int E203_INDEP_MUL_WBCK_BUF_DEPTH  = 2;

  localparam int BUF_COUNT_WIDTH = 3;

endpackage

// File: rtl/e203_exu_wbck_fifo_entry.sv
// One buffered write-back slot: valid bit, result data, destination index and
// source-index comparators for the dispatch dependency check.
module e203_exu_wbck_fifo_entry #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_set,
  input  logic                   i_clr,
  input  logic [XLEN-1:0]        i_wdat,
  input  logic [RFIDX_WIDTH-1:0] i_rdidx,
  input  logic [RFIDX_WIDTH-1:0] i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] i_rs2idx,
  output logic [XLEN-1:0]        o_wdat,
  output logic [RFIDX_WIDTH-1:0] o_rdidx,
  output logic                   o_rs1_hit,
  output logic                   o_rs2_hit
);

  logic                   r_valid;
  logic [XLEN-1:0]        r_wdat;
  logic [RFIDX_WIDTH-1:0] r_rdidx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is meaningless while r_valid is low, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_set) begin
      r_wdat  <= i_wdat;
      r_rdidx <= i_rdidx;
    end
  end

  assign o_wdat    = r_wdat;
  assign o_rdidx   = r_rdidx;
  // x0 is never a real dependency, so index 0 never reports a hit.
  assign o_rs1_hit = r_valid && (r_rdidx == i_rs1idx) && (i_rs1idx != '0);
  assign o_rs2_hit = r_valid && (r_rdidx == i_rs2idx) && (i_rs2idx != '0);

endmodule

// File: rtl/e203_exu_indep_mul_wbck_buf.sv
// Small FIFO between the single-cycle multiplier and the EXU write-back
// arbiter, with a register-dependency check over the buffered destinations.
module e203_exu_indep_mul_wbck_buf
  import e203_exu_indep_mul_wbck_buf_pkg::*;
#(
  parameter int XLEN        = E203_XLEN,
  parameter int RFIDX_WIDTH = E203_RFIDX_WIDTH,
  parameter int DEPTH       = E203_INDEP_MUL_WBCK_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mul_o_valid,
  output logic                       mul_o_ready,
  input  logic [XLEN-1:0]            mul_o_wdat,
  input  logic [RFIDX_WIDTH-1:0]     mul_o_rdidx,
  output logic                       indep_mul_wbck_o_valid,
  input  logic                       indep_mul_wbck_o_ready,
  output logic [XLEN-1:0]            indep_mul_wbck_o_wdat,
  output logic [RFIDX_WIDTH-1:0]     indep_mul_wbck_o_rdidx,
  input  logic [RFIDX_WIDTH-1:0]     dep_chk_rs1idx,
  input  logic [RFIDX_WIDTH-1:0]     dep_chk_rs2idx,
  output logic                       dep_chk_rs1_hit,
  output logic                       dep_chk_rs2_hit,
  output logic                       buf_empty,
  output logic [BUF_COUNT_WIDTH-1:0] buf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [BUF_COUNT_WIDTH-1:0] CNT_FULL = BUF_COUNT_WIDTH'(DEPTH);

  logic [PTR_W-1:0]           r_rptr;
  logic [PTR_W-1:0]           r_wptr;
  logic [BUF_COUNT_WIDTH-1:0] r_count;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [DEPTH-1:0]       w_set;
  logic [DEPTH-1:0]       w_clr;
  logic [DEPTH-1:0]       w_rs1_hit;
  logic [DEPTH-1:0]       w_rs2_hit;
  logic [XLEN-1:0]        w_ent_wdat  [DEPTH];
  logic [RFIDX_WIDTH-1:0] w_ent_rdidx [DEPTH];

  // Handshakes: a transfer happens on a cycle where valid && ready at the
  // rising edge; valid and payload hold until then. mul_o_ready depends on
  // registered occupancy only, so a full buffer refuses a push even when the
  // arbiter pops in the same cycle.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = mul_o_valid && !w_full;
  assign w_pop   = !w_empty && indep_mul_wbck_o_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_set[g] = w_push && (r_wptr == PTR_W'(g));
    assign w_clr[g] = w_pop  && (r_rptr == PTR_W'(g));

    e203_exu_wbck_fifo_entry #(
      .XLEN        (XLEN),
      .RFIDX_WIDTH (RFIDX_WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .i_set     (w_set[g]),
      .i_clr     (w_clr[g]),
      .i_wdat    (mul_o_wdat),
      .i_rdidx   (mul_o_rdidx),
      .i_rs1idx  (dep_chk_rs1idx),
      .i_rs2idx  (dep_chk_rs2idx),
      .o_wdat    (w_ent_wdat[g]),
      .o_rdidx   (w_ent_rdidx[g]),
      .o_rs1_hit (w_rs1_hit[g]),
      .o_rs2_hit (w_rs2_hit[g])
    );
  end

  // Pointers wrap explicitly so non-power-of-two-free depths (and DEPTH=1,
  // where both stay at 0) behave the same way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mul_o_ready            = !w_full;
  assign indep_mul_wbck_o_valid = !w_empty;
  assign indep_mul_wbck_o_wdat  = w_ent_wdat[r_rptr];
  assign indep_mul_wbck_o_rdidx = w_ent_rdidx[r_rptr];
  assign dep_chk_rs1_hit        = |w_rs1_hit;
  assign dep_chk_rs2_hit        = |w_rs2_hit;
  assign buf_empty              = w_empty;
  assign buf_count              = r_count;

endmodule
